// File: rtl/integral_image_gen.sv
// Streaming integral-image generator: row accumulator plus one-row line buffer of previous-row ii.
// Optional squared-sum path enabled by defining SQ_SUM_EN.
module integral_image_gen #(
    parameter int unsigned IMG_WIDTH  = 64,
    parameter int unsigned IMG_HEIGHT = 64,
    parameter int unsigned SUM_W      = 20,
    parameter int unsigned SQ_W       = 28
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             pix_valid,
    output logic             pix_ready,
    input  logic [7:0]       pix_data,
    output logic             ii_valid,
    input  logic             ii_ready,
    output logic [SUM_W-1:0] ii_data,
`ifdef SQ_SUM_EN
    output logic [SQ_W-1:0]  ii_sq_data,
`endif
    output logic             busy,
    output logic             done
);

    localparam int unsigned NPIX = IMG_WIDTH * IMG_HEIGHT;
    localparam int unsigned XW   = $clog2(IMG_WIDTH);
    localparam int unsigned YW   = $clog2(IMG_HEIGHT);
    localparam int unsigned CW   = $clog2(NPIX + 1);

    // Elaboration-time guard on parameter legality
    if (IMG_WIDTH < 2 || IMG_HEIGHT < 2 || SUM_W < 8 + $clog2(NPIX) || SQ_W < 16 + $clog2(NPIX))
    begin : g_param_check
        $error("integral_image_gen: illegal parameter combination");
    end

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t            state, state_nxt;
    logic [XW-1:0]     x;
    logic [YW-1:0]     y;
    logic [CW-1:0]     in_cnt, out_cnt;
    logic [SUM_W-1:0]  row_acc, rs, up, ii;
    logic [SUM_W-1:0]  lbuf [IMG_WIDTH];
    logic              accept, drain, last_out;

    assign accept    = pix_valid && pix_ready;
    assign drain     = ii_valid && ii_ready;
    assign last_out  = drain && (out_cnt == CW'(NPIX - 1));
    assign pix_ready = (state == S_RUN) && (!ii_valid || ii_ready) && (in_cnt < CW'(NPIX));
    assign busy      = (state == S_RUN);
    assign done      = (state == S_DONE);

    // Row 0 takes zero from above, so the unreset line buffer is never observed stale
    assign rs = ((x == '0) ? '0 : row_acc) + SUM_W'(pix_data);
    assign up = (y == '0) ? '0 : lbuf[x];
    assign ii = up + rs;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (last_out) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x        <= '0;
            y        <= '0;
            row_acc  <= '0;
            in_cnt   <= '0;
            out_cnt  <= '0;
            ii_valid <= 1'b0;
            ii_data  <= '0;
        end else begin
            if (state == S_IDLE && start) begin
                x       <= '0;
                y       <= '0;
                row_acc <= '0;
                in_cnt  <= '0;
                out_cnt <= '0;
            end
            if (accept) begin
                row_acc <= rs;
                in_cnt  <= in_cnt + 1'b1;
                if (x == XW'(IMG_WIDTH - 1)) begin
                    x <= '0;
                    y <= y + 1'b1;
                end else begin
                    x <= x + 1'b1;
                end
            end
            if (drain) out_cnt <= out_cnt + 1'b1;
            // Output register reloads on accept, otherwise holds until drained
            if (accept) begin
                ii_valid <= 1'b1;
                ii_data  <= ii;
            end else if (ii_ready) begin
                ii_valid <= 1'b0;
            end
        end
    end

    // Read-before-write: lbuf[x] feeds up in the same cycle it is overwritten
    always_ff @(posedge clk) begin
        if (accept) lbuf[x] <= ii;
    end

`ifdef SQ_SUM_EN
    logic [SQ_W-1:0] sq_acc, sq_pix, rs_sq, up_sq, ii_sq;
    logic [SQ_W-1:0] lbuf_sq [IMG_WIDTH];

    assign sq_pix = SQ_W'(pix_data) * SQ_W'(pix_data);
    assign rs_sq  = ((x == '0) ? '0 : sq_acc) + sq_pix;
    assign up_sq  = (y == '0) ? '0 : lbuf_sq[x];
    assign ii_sq  = up_sq + rs_sq;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sq_acc     <= '0;
            ii_sq_data <= '0;
        end else begin
            if (state == S_IDLE && start) sq_acc <= '0;
            if (accept) begin
                sq_acc     <= rs_sq;
                ii_sq_data <= ii_sq;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) lbuf_sq[x] <= ii_sq;
    end
`endif

endmodule

// File: tb/tb_integral_image_gen.sv
// Self-checking bench for integral_image_gen; reference ii built by inclusion-exclusion over the frame.
module tb_integral_image_gen;

    localparam int W      = 64;
    localparam int H      = 64;
    localparam int NPIX   = W * H;
    localparam int BUDGET = 30000;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        pix_valid;
    logic        pix_ready;
    logic [7:0]  pix_data;
    logic        ii_valid;
    logic        ii_ready;
    logic [19:0] ii_data;
    logic        busy;
    logic        done;
`ifdef SQ_SUM_EN
    logic [27:0] ii_sq_data;
`endif

    integral_image_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .SUM_W(20), .SQ_W(28)) dut (
        .clk(clk), .reset(reset), .start(start),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .ii_valid(ii_valid), .ii_ready(ii_ready), .ii_data(ii_data),
`ifdef SQ_SUM_EN
        .ii_sq_data(ii_sq_data),
`endif
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    int          pix    [NPIX];
    int          refv   [NPIX];
    int          ref_sq [NPIX];
    logic [19:0] got    [NPIX];
    logic [27:0] got_sq [NPIX];
    int nout, ndone, done_cyc, done_lag, stall_bad, gap_out, extra_acc;
    bit timeout;

    // mode 0: all 1, 1: all 255, 2: ramp x, 3: random
    task automatic gen_frame(input int mode);
        for (int yy = 0; yy < H; yy++)
            for (int xx = 0; xx < W; xx++) begin
                int i;
                i = yy * W + xx;
                case (mode)
                    0: pix[i] = 1;
                    1: pix[i] = 255;
                    2: pix[i] = xx;
                    default: pix[i] = int'($urandom_range(255));
                endcase
            end
        for (int yy = 0; yy < H; yy++)
            for (int xx = 0; xx < W; xx++) begin
                int i, a, b, c, sa, sb, sc;
                i = yy * W + xx;
                a = (xx > 0) ? refv[i-1] : 0;
                b = (yy > 0) ? refv[i-W] : 0;
                c = (xx > 0 && yy > 0) ? refv[i-W-1] : 0;
                refv[i] = pix[i] + a + b - c;
                sa = (xx > 0) ? ref_sq[i-1] : 0;
                sb = (yy > 0) ? ref_sq[i-W] : 0;
                sc = (xx > 0 && yy > 0) ? ref_sq[i-W-1] : 0;
                ref_sq[i] = pix[i] * pix[i] + sa + sb - sc;
            end
    endtask

    // Drives one frame and records what came out; comparisons live in the scenario tasks
    task automatic run_frame(input int mode, input int rdy_pct, input int vld_pct,
                             input int start_at, input int gap_at, input int abort_at);
        int in_idx, cyc, last_hs, gap_left, gap_idx;
        bit start_sent, prev_stall;
        logic [19:0] prev_data;
        gen_frame(mode);
        nout = 0; ndone = 0; done_cyc = -1; stall_bad = 0; gap_out = 0;
        extra_acc = 0; timeout = 0; last_hs = -1;
        in_idx = 0; cyc = 0; gap_left = 0; gap_idx = -1;
        start_sent = 0; prev_stall = 0; prev_data = '0;
        @(posedge clk); #1;
        start = 1'b1; pix_valid = 1'b0; ii_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (1) begin
            if (gap_at >= 0 && in_idx == gap_at && gap_idx < 0) begin
                gap_left = 20;
                gap_idx  = 0;
            end
            if (in_idx >= NPIX) pix_valid = 1'b1;
            else pix_valid = (gap_left == 0) && (int'($urandom_range(99)) < vld_pct);
            pix_data = (in_idx < NPIX) ? 8'(pix[in_idx]) : 8'hAA;
            ii_ready = int'($urandom_range(99)) < rdy_pct;
            start = (start_at >= 0 && in_idx == start_at && !start_sent);
            if (start) start_sent = 1;
            #1;
            if (done) begin
                ndone++;
                done_cyc = cyc;
            end
            if (in_idx >= NPIX && pix_ready) extra_acc++;
            if (prev_stall && (!ii_valid || ii_data !== prev_data)) stall_bad++;
            if (gap_left > 0) begin
                if (gap_idx >= 1 && ii_valid) gap_out++;
                gap_idx++;
                gap_left--;
            end
            if (ii_valid && ii_ready) begin
                if (nout < NPIX) begin
                    got[nout] = ii_data;
`ifdef SQ_SUM_EN
                    got_sq[nout] = ii_sq_data;
`endif
                end
                nout++;
                last_hs = cyc;
            end
            prev_stall = ii_valid && !ii_ready;
            prev_data  = ii_data;
            if (pix_valid && pix_ready) in_idx++;
            cyc++;
            if (abort_at >= 0 && in_idx == abort_at) break;
            if (done_cyc >= 0 && cyc > done_cyc + 3) break;
            if (cyc >= BUDGET) begin
                timeout = 1;
                break;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        done_lag = done_cyc - last_hs;
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; pix_valid = 1'b0; pix_data = '0; ii_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (ii_valid !== 1'b0) begin n_fails++; $display("FAIL reset_ii_valid: got %0b expected 0", ii_valid); end
        n_checks++; if (ii_data !== 20'd0) begin n_fails++; $display("FAIL reset_ii_data: got %0d expected 0", ii_data); end
        n_checks++; if (pix_ready !== 1'b0) begin n_fails++; $display("FAIL reset_pix_ready: got %0b expected 0", pix_ready); end
        n_checks++; if ({busy, done} !== 2'b00) begin n_fails++; $display("FAIL reset_busy_done: got %b expected 00", {busy, done}); end
        reset = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (pix_ready !== 1'b0) begin n_fails++; $display("FAIL idle_pix_ready: got %0b expected 0", pix_ready); end
    endtask

    task automatic test_all_ones;
        run_frame(0, 100, 100, -1, -1, -1);
        n_checks++; if (timeout) begin n_fails++; $display("FAIL ones_timeout: got timeout expected completion"); end
        n_checks++; if (nout !== NPIX) begin n_fails++; $display("FAIL ones_count: got %0d expected %0d", nout, NPIX); end
        for (int i = 0; i < NPIX && i < nout; i++) begin
            n_checks++;
            if (got[i] !== 20'(refv[i])) begin
                n_fails++; $display("FAIL ones_seq[%0d]: got %0d expected %0d", i, got[i], refv[i]); break;
            end
        end
        n_checks++; if (got[NPIX-1] !== 20'd4096) begin n_fails++; $display("FAIL ones_last: got %0d expected 4096", got[NPIX-1]); end
        n_checks++; if (got[W+5] !== 20'd12) begin n_fails++; $display("FAIL ones_ii_5_1: got %0d expected 12", got[W+5]); end
        n_checks++; if (ndone !== 1) begin n_fails++; $display("FAIL ones_done_count: got %0d expected 1", ndone); end
        n_checks++; if (done_lag !== 1) begin n_fails++; $display("FAIL ones_done_lag: got %0d expected 1", done_lag); end
        n_checks++; if (extra_acc !== 0) begin n_fails++; $display("FAIL ones_extra_accept: got %0d expected 0", extra_acc); end
    endtask

    task automatic test_all_255;
        run_frame(1, 100, 100, -1, -1, -1);
        n_checks++; if (nout !== NPIX) begin n_fails++; $display("FAIL max_count: got %0d expected %0d", nout, NPIX); end
        n_checks++; if (got[NPIX-1] !== 20'hFF000) begin n_fails++; $display("FAIL max_last: got %h expected ff000", got[NPIX-1]); end
        n_checks++; if (got[W-1] !== 20'(255 * W)) begin n_fails++; $display("FAIL max_row0_end: got %0d expected %0d", got[W-1], 255 * W); end
`ifdef SQ_SUM_EN
        n_checks++; if (got_sq[NPIX-1] !== 28'd266342400) begin n_fails++; $display("FAIL max_sq_last: got %0d expected 266342400", got_sq[NPIX-1]); end
`endif
    endtask

    task automatic test_ramp_backpressure;
        run_frame(2, 50, 100, -1, -1, -1);
        n_checks++; if (timeout) begin n_fails++; $display("FAIL ramp_timeout: got timeout expected completion"); end
        n_checks++; if (nout !== NPIX) begin n_fails++; $display("FAIL ramp_count: got %0d expected %0d", nout, NPIX); end
        for (int i = 0; i < NPIX && i < nout; i++) begin
            n_checks++;
            if (got[i] !== 20'(refv[i])) begin
                n_fails++; $display("FAIL ramp_seq[%0d]: got %0d expected %0d", i, got[i], refv[i]); break;
            end
        end
        n_checks++; if (stall_bad !== 0) begin n_fails++; $display("FAIL ramp_stall_stable: got %0d violations expected 0", stall_bad); end
        n_checks++; if (got[W-1] !== 20'd2016) begin n_fails++; $display("FAIL ramp_ii_63_0: got %0d expected 2016", got[W-1]); end
        n_checks++; if (got[NPIX-1] !== 20'd129024) begin n_fails++; $display("FAIL ramp_ii_63_63: got %0d expected 129024", got[NPIX-1]); end
        n_checks++; if (ndone !== 1) begin n_fails++; $display("FAIL ramp_done_count: got %0d expected 1", ndone); end
    endtask

    task automatic test_start_in_run;
        run_frame(3, 80, 90, 100, -1, -1);
        n_checks++; if (nout !== NPIX) begin n_fails++; $display("FAIL start_run_count: got %0d expected %0d", nout, NPIX); end
        for (int i = 0; i < NPIX && i < nout; i++) begin
            n_checks++;
            if (got[i] !== 20'(refv[i])) begin
                n_fails++; $display("FAIL start_run_seq[%0d]: got %0d expected %0d", i, got[i], refv[i]); break;
            end
        end
        n_checks++; if (ndone !== 1) begin n_fails++; $display("FAIL start_run_done_count: got %0d expected 1", ndone); end
        n_checks++; if (done_lag !== 1) begin n_fails++; $display("FAIL start_run_done_lag: got %0d expected 1", done_lag); end
    endtask

    task automatic test_reset_mid_frame;
        run_frame(1, 100, 100, -1, -1, 1000);
        @(posedge clk); #1;
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++;
            if ({ii_valid, pix_ready, busy, done, ii_data} !== 24'd0) begin
                n_fails++;
                $display("FAIL midreset_outputs_zero: got v=%0b r=%0b b=%0b d=%0b data=%0d expected all 0",
                         ii_valid, pix_ready, busy, done, ii_data);
            end
            @(posedge clk);
        end
        #1;
        reset = 1'b0;
        run_frame(0, 100, 100, -1, -1, -1);
        n_checks++; if (nout !== NPIX) begin n_fails++; $display("FAIL midreset_count: got %0d expected %0d", nout, NPIX); end
        for (int i = 0; i < NPIX && i < nout; i++) begin
            n_checks++;
            if (got[i] !== 20'(refv[i])) begin
                n_fails++; $display("FAIL midreset_seq[%0d]: got %0d expected %0d", i, got[i], refv[i]); break;
            end
        end
        n_checks++; if (ndone !== 1) begin n_fails++; $display("FAIL midreset_done_count: got %0d expected 1", ndone); end
    endtask

    task automatic test_row_gap;
        run_frame(0, 100, 100, -1, W, -1);
        n_checks++; if (gap_out !== 0) begin n_fails++; $display("FAIL gap_no_output: got %0d valid cycles expected 0", gap_out); end
        n_checks++; if (got[W] !== 20'd2) begin n_fails++; $display("FAIL gap_ii_0_1: got %0d expected 2", got[W]); end
        n_checks++; if (got[2*W-1] !== 20'd128) begin n_fails++; $display("FAIL gap_ii_63_1: got %0d expected 128", got[2*W-1]); end
        n_checks++; if (got[NPIX-1] !== 20'd4096) begin n_fails++; $display("FAIL gap_last: got %0d expected 4096", got[NPIX-1]); end
    endtask

    task automatic test_random_frame;
        run_frame(3, 60, 60, -1, -1, -1);
        n_checks++; if (nout !== NPIX) begin n_fails++; $display("FAIL rand_count: got %0d expected %0d", nout, NPIX); end
        for (int i = 0; i < NPIX && i < nout; i++) begin
            n_checks++;
            if (got[i] !== 20'(refv[i])) begin
                n_fails++; $display("FAIL rand_seq[%0d]: got %0d expected %0d", i, got[i], refv[i]); break;
            end
`ifdef SQ_SUM_EN
            n_checks++;
            if (got_sq[i] !== 28'(ref_sq[i])) begin
                n_fails++; $display("FAIL rand_sq_seq[%0d]: got %0d expected %0d", i, got_sq[i], ref_sq[i]); break;
            end
`endif
        end
        n_checks++; if (stall_bad !== 0) begin n_fails++; $display("FAIL rand_stall_stable: got %0d violations expected 0", stall_bad); end
        n_checks++; if (done_lag !== 1) begin n_fails++; $display("FAIL rand_done_lag: got %0d expected 1", done_lag); end
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_all_255();
        test_ramp_backpressure();
        test_start_in_run();
        test_reset_mid_frame();
        test_row_gap();
        test_random_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
